// File: rtl/jcnt_pkg.sv
// Shared definitions for Johnson-code monitors and benches: state encoding,
// index width helper and the Johnson position successor.
package jcnt_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQ      = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

  // Position that legally follows idx in a 2n-state Johnson sequence.
  function automatic int jc_succ(input int idx, input int n);
    return (idx == 2 * n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/jcnt_monitor_if.sv
// Sample/status bundle between a Johnson-code source and jcnt_monitor.
// valid/ready is not used: the source qualifies q with en, and the monitor
// accepts every en=1 sample unconditionally (no backpressure).
interface jcnt_monitor_if
  import jcnt_pkg::*;
#(
  parameter int N    = 8,
  parameter int ERRW = 8,
  parameter int REVW = 8
);
  localparam int IDXW = idx_width(N);

  logic            en;
  logic [N-1:0]    q;
  logic [IDXW-1:0] idx;
  logic            valid;
  logic            locked;
  logic            illegal;
  logic            seq_err;
  logic            wrap;
  logic [ERRW-1:0] err_cnt;
  logic [REVW-1:0] rev_cnt;
  state_e          state;

  modport master (
    output en, q,
    input  idx, valid, locked, illegal, seq_err, wrap, err_cnt, rev_cnt, state
  );

  modport slave (
    input  en, q,
    output idx, valid, locked, illegal, seq_err, wrap, err_cnt, rev_cnt, state
  );
endinterface

// File: rtl/jcnt_code_decode.sv
// Combinational Johnson-code decoder: flags legal codes and returns their
// position 0..2N-1 (k low ones -> k, all-ones with k low zeros -> N+k).
module jcnt_code_decode
  import jcnt_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    q_i,
  output logic            legal_o,
  output logic [IDXW-1:0] idx_o
);

  function automatic logic [N-1:0] low_ones(input int k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = (i < k);
    end
    return r;
  endfunction

  always_comb begin
    legal_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      if (q_i == low_ones(k)) begin
        legal_o = 1'b1;
        idx_o   = IDXW'(k);
      end
      if (q_i == ~low_ones(k)) begin
        legal_o = 1'b1;
        idx_o   = IDXW'(N + k);
      end
    end
  end

endmodule

// File: rtl/jcnt_monitor.sv
// Johnson-code bus checker: decodes each sampled code, tracks lock via a
// good-step counter, and reports illegal/sequence errors, wraps and counts.
module jcnt_monitor
  import jcnt_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOCK_N = 4,
  parameter int ERRW   = 8,
  parameter int REVW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  jcnt_monitor_if.slave bus
);

  localparam int IDXW = idx_width(N);
  localparam int GW   = $clog2(LOCK_N + 1);
  localparam int LAST = 2 * N - 1;

  logic            dec_legal;
  logic [IDXW-1:0] dec_idx;
  logic            is_succ;

  state_e          state_q,   state_d;
  logic [IDXW-1:0] idx_q,     idx_d;
  logic            valid_q,   valid_d;
  logic [GW-1:0]   good_q,    good_d;
  logic            illegal_q, illegal_d;
  logic            seq_err_q, seq_err_d;
  logic            wrap_q,    wrap_d;
  logic [ERRW-1:0] err_q,     err_d;
  logic [REVW-1:0] rev_q,     rev_d;
  logic            err_inc;

  jcnt_code_decode #(.N(N), .IDXW(IDXW)) u_dec (
    .q_i     (bus.q),
    .legal_o (dec_legal),
    .idx_o   (dec_idx)
  );

  assign is_succ = (dec_idx == IDXW'(jc_succ(int'(idx_q), N)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    good_d    = good_q;
    illegal_d = 1'b0;
    seq_err_d = 1'b0;
    wrap_d    = 1'b0;
    err_inc   = 1'b0;
    if (bus.en) begin
      case (state_q)
        ST_UNLOCKED: begin
          // Errors while unlocked are expected noise and are not counted.
          if (dec_legal) begin
            state_d = ST_ACQ;
            idx_d   = dec_idx;
            valid_d = 1'b1;
            good_d  = '0;
          end else begin
            illegal_d = 1'b1;
          end
        end
        ST_ACQ, ST_LOCKED: begin
          if (!dec_legal) begin
            state_d   = ST_UNLOCKED;
            valid_d   = 1'b0;
            illegal_d = 1'b1;
            err_inc   = 1'b1;
          end else if (!is_succ) begin
            state_d   = ST_ACQ;
            idx_d     = dec_idx;
            good_d    = '0;
            seq_err_d = 1'b1;
            err_inc   = 1'b1;
          end else begin
            idx_d = dec_idx;
            if (state_q == ST_LOCKED) begin
              wrap_d = (idx_q == IDXW'(LAST));
            end else if (good_q == GW'(LOCK_N - 1)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          valid_d = 1'b0;
          good_d  = '0;
        end
      endcase
    end
    err_d = (err_inc && (err_q != {ERRW{1'b1}})) ? err_q + ERRW'(1) : err_q;
    rev_d = wrap_d ? rev_q + REVW'(1) : rev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_UNLOCKED;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      good_q    <= '0;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= '0;
      rev_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      good_q    <= good_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      rev_q     <= rev_d;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.valid   = valid_q;
  assign bus.locked  = (state_q == ST_LOCKED);
  assign bus.illegal = illegal_q;
  assign bus.seq_err = seq_err_q;
  assign bus.wrap    = wrap_q;
  assign bus.err_cnt = err_q;
  assign bus.rev_cnt = rev_q;
  assign bus.state   = state_q;

endmodule
